// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use interlock and branch flush.
// Optional feature macro: FWD_EN enables EX/WB forwarding and held-operand refresh.
module id_ex_stage #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:INSTR_W-1] in_instr,
    input  logic [0:DATA_W-1] in_rA_val,
    input  logic [0:DATA_W-1] in_rB_val,
    input  logic              flush,
    input  logic              ex_wr_en,
    input  logic [0:4]        ex_wr_addr,
    input  logic [0:DATA_W-1] ex_wr_data,
    input  logic              wb_wr_en,
    input  logic [0:4]        wb_wr_addr,
    input  logic [0:DATA_W-1] wb_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:5]        Op_code,
    output logic [0:5]        R_ins,
    output logic [0:1]        WW,
    output logic [0:4]        rD_addr,
    output logic [0:DATA_W-1] rA_64bit_val,
    output logic [0:DATA_W-1] rB_64bit_val
);

    localparam logic [0:5] OP_LOAD = 6'b100000;

    logic              valid_q, valid_d;
    logic [0:5]        op_q, op_d;
    logic [0:5]        rins_q, rins_d;
    logic [0:1]        ww_q, ww_d;
    logic [0:4]        rd_q, rd_d;
    logic [0:4]        src_a_q, src_a_d;
    logic [0:4]        src_b_q, src_b_d;
    logic [0:DATA_W-1] a_q, a_d;
    logic [0:DATA_W-1] b_q, b_d;

    logic [0:5] f_op, f_rins;
    logic [0:4] f_rd, f_ra, f_rb;
    logic [0:1] f_ww;
    logic       load_use, in_fire, out_fire;

    assign f_op   = in_instr[0:5];
    assign f_rd   = in_instr[6:10];
    assign f_ra   = in_instr[11:15];
    assign f_rb   = in_instr[16:20];
    assign f_ww   = in_instr[24:25];
    assign f_rins = in_instr[26:31];

    // Conservative: both source fields count as reads for every opcode.
    assign load_use = valid_q && (op_q == OP_LOAD) && (rd_q != 5'd0) && in_valid
                      && ((f_ra == rd_q) || (f_rb == rd_q));

    assign in_ready = (!valid_q || out_ready) && !flush && !load_use;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

`ifdef FWD_EN
    function automatic logic [0:DATA_W-1] fwd(input logic [0:4] src,
                                              input logic [0:DATA_W-1] dflt);
        logic [0:DATA_W-1] r;
        r = dflt;
        if (src == 5'd0)                           r = '0;
        else if (ex_wr_en && (ex_wr_addr == src))  r = ex_wr_data;
        else if (wb_wr_en && (wb_wr_addr == src))  r = wb_wr_data;
        return r;
    endfunction
`else
    function automatic logic [0:DATA_W-1] fwd(input logic [0:4] src,
                                              input logic [0:DATA_W-1] dflt);
        return (src == 5'd0) ? '0 : dflt;
    endfunction

    logic unused_fwd;
    assign unused_fwd = ^{ex_wr_en, ex_wr_addr, ex_wr_data,
                          wb_wr_en, wb_wr_addr, wb_wr_data};
`endif

    logic unused_instr;
    assign unused_instr = ^in_instr[21:23];

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        rins_d  = rins_q;
        ww_d    = ww_q;
        rd_d    = rd_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        a_d     = a_q;
        b_d     = b_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d = 1'b1;
            op_d    = f_op;
            rins_d  = f_rins;
            ww_d    = f_ww;
            rd_d    = f_rd;
            src_a_d = f_ra;
            src_b_d = f_rb;
            a_d     = fwd(f_ra, in_rA_val);
            b_d     = fwd(f_rb, in_rB_val);
        end else if (out_fire) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
`ifdef FWD_EN
            // Stalled: pick up any writeback passing the held instruction.
            a_d = fwd(src_a_q, a_q);
            b_d = fwd(src_b_q, b_q);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rins_q  <= '0;
            ww_q    <= '0;
            rd_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            rins_q  <= rins_d;
            ww_q    <= ww_d;
            rd_q    <= rd_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign out_valid    = valid_q;
    assign Op_code      = op_q;
    assign R_ins        = rins_q;
    assign WW           = ww_q;
    assign rD_addr      = rd_q;
    assign rA_64bit_val = a_q;
    assign rB_64bit_val = b_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; expectations follow FWD_EN when it is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] in_instr;
    logic [0:63] in_rA_val, in_rB_val;
    logic        flush;
    logic        ex_wr_en, wb_wr_en;
    logic [0:4]  ex_wr_addr, wb_wr_addr;
    logic [0:63] ex_wr_data, wb_wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:5]  Op_code, R_ins;
    logic [0:1]  WW;
    logic [0:4]  rD_addr;
    logic [0:63] rA_64bit_val, rB_64bit_val;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [5:0] OP_VADD = 6'b101010;
    localparam logic [5:0] OP_LOAD = 6'b100000;
    localparam logic [5:0] OP_VAND = 6'b101100;
    localparam logic [5:0] OP_VOR  = 6'b101101;
    localparam logic [5:0] OP_NOP  = 6'b111100;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rA_val(in_rA_val), .in_rB_val(in_rB_val),
        .flush(flush), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
        .ex_wr_data(ex_wr_data), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_wr_data(wb_wr_data), .out_valid(out_valid), .out_ready(out_ready),
        .Op_code(Op_code), .R_ins(R_ins), .WW(WW), .rD_addr(rD_addr),
        .rA_64bit_val(rA_64bit_val), .rB_64bit_val(rB_64bit_val)
    );

    function automatic logic [0:31] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [1:0] ww, input logic [5:0] ri);
        logic [0:31] w;
        w = '0;
        w[0:5] = op; w[6:10] = rd; w[11:15] = ra; w[16:20] = rb;
        w[24:25] = ww; w[26:31] = ri;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_instr = '0; in_rA_val = '0; in_rB_val = '0; flush = 0;
        ex_wr_en = 0; ex_wr_addr = '0; ex_wr_data = '0;
        wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0; out_ready = 1;
    endtask

    task automatic drain();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_init_valid got=%0b want=0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_init_ready got=%0b want=1", in_ready); end
        in_valid = 1; in_instr = mk(OP_VADD, 5'd2, 5'd3, 5'd4, 2'b10, 6'b000110);
        in_rA_val = 64'h1234; in_rB_val = 64'h5678; out_ready = 0;
        step();
        in_valid = 0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL reset_pre_valid got=%0b want=1", out_valid); end
        #2 rst_n = 0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_async_valid got=%0b want=0", out_valid); end
        vectors++; if ({Op_code, R_ins, WW, rD_addr} !== 19'd0) begin miscompares++; $display("FAIL reset_async_fields got=%h want=0", {Op_code, R_ins, WW, rD_addr}); end
        vectors++; if ({rA_64bit_val, rB_64bit_val} !== 128'd0) begin miscompares++; $display("FAIL reset_async_ops got=%h want=0", {rA_64bit_val, rB_64bit_val}); end
        #1 rst_n = 1;
        out_ready = 1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got=%0b want=1", in_ready); end
        step();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        in_valid = 1; in_rA_val = 64'h1; in_rB_val = 64'h2;
        for (int i = 1; i <= 3; i++) begin
            in_instr = mk(OP_VADD, 5'(i), 5'd3, 5'd4, 2'b10, 6'b000110);
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got=%0b want=1", i, in_ready); end
            step();
            vectors++; if (out_valid !== 1'b1 || rD_addr !== 5'(i)) begin miscompares++; $display("FAIL b2b_issue[%0d] got v=%0b rd=%0d want v=1 rd=%0d", i, out_valid, rD_addr, i); end
            vectors++; if ({Op_code, R_ins, WW} !== {6'b101010, 6'b000110, 2'b10}) begin miscompares++; $display("FAIL b2b_fields[%0d] got=%b want=%b", i, {Op_code, R_ins, WW}, {6'b101010, 6'b000110, 2'b10}); end
            vectors++; if (rA_64bit_val !== 64'h1 || rB_64bit_val !== 64'h2) begin miscompares++; $display("FAIL b2b_ops[%0d] got=%h/%h want=1/2", i, rA_64bit_val, rB_64bit_val); end
        end
        in_valid = 0;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got=%0b want=0", out_valid); end
    endtask

    task automatic test_ex_forward();
        logic [0:63] exp;
        idle_inputs();
        in_valid = 1; in_instr = mk(OP_VADD, 5'd1, 5'd5, 5'd6, 2'b00, 6'd0);
        in_rA_val = 64'h1111; in_rB_val = 64'h2222;
        ex_wr_en = 1; ex_wr_addr = 5'd5; ex_wr_data = 64'hAA;
        wb_wr_en = 1; wb_wr_addr = 5'd5; wb_wr_data = 64'hBB;
        step();
`ifdef FWD_EN
        exp = 64'hAA;
`else
        exp = 64'h1111;
`endif
        vectors++; if (rA_64bit_val !== exp) begin miscompares++; $display("FAIL fwd_ex_prio got=%h want=%h", rA_64bit_val, exp); end
        vectors++; if (rB_64bit_val !== 64'h2222) begin miscompares++; $display("FAIL fwd_nomatch got=%h want=2222", rB_64bit_val); end
        in_instr = mk(OP_VADD, 5'd1, 5'd6, 5'd7, 2'b00, 6'd0);
        wb_wr_addr = 5'd6;
        step();
`ifdef FWD_EN
        exp = 64'hBB;
`else
        exp = 64'h1111;
`endif
        vectors++; if (rA_64bit_val !== exp) begin miscompares++; $display("FAIL fwd_wb got=%h want=%h", rA_64bit_val, exp); end
        in_instr = mk(OP_VADD, 5'd1, 5'd0, 5'd0, 2'b00, 6'd0);
        ex_wr_addr = 5'd0; wb_wr_addr = 5'd0;
        step();
        vectors++; if (rA_64bit_val !== 64'h0 || rB_64bit_val !== 64'h0) begin miscompares++; $display("FAIL fwd_r0 got=%h/%h want=0/0", rA_64bit_val, rB_64bit_val); end
        drain();
    endtask

    task automatic test_load_use();
        idle_inputs();
        in_valid = 1; in_instr = mk(OP_LOAD, 5'd7, 5'd1, 5'd2, 2'b00, 6'd0); out_ready = 0;
        step();
        vectors++; if (out_valid !== 1'b1 || Op_code !== OP_LOAD) begin miscompares++; $display("FAIL lu_hold got v=%0b op=%b want v=1 op=100000", out_valid, Op_code); end
        in_instr = mk(OP_VAND, 5'd8, 5'd3, 5'd7, 2'b01, 6'd0); out_ready = 1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL lu_ready_low got=%0b want=0", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got=%0b want=0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_ready_back got=%0b want=1", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b1 || Op_code !== OP_VAND || rD_addr !== 5'd8) begin miscompares++; $display("FAIL lu_capture got v=%0b op=%b rd=%0d want v=1 op=101100 rd=8", out_valid, Op_code, rD_addr); end
        // LOAD to R0 never interlocks
        in_instr = mk(OP_LOAD, 5'd0, 5'd1, 5'd2, 2'b00, 6'd0);
        step();
        in_instr = mk(OP_NOP, 5'd0, 5'd0, 5'd0, 2'b00, 6'd0);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_r0 got=%0b want=1", in_ready); end
        drain();
    endtask

    task automatic test_stall_refresh();
        logic [0:63] exp;
        idle_inputs();
        in_valid = 1; in_instr = mk(OP_VOR, 5'd11, 5'd9, 5'd10, 2'b11, 6'd0);
        in_rA_val = 64'h11; in_rB_val = 64'h22; out_ready = 0;
        step();
        in_valid = 0;
        vectors++; if (rA_64bit_val !== 64'h11) begin miscompares++; $display("FAIL sr_capture got=%h want=11", rA_64bit_val); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL sr_ready got=%0b want=0", in_ready); end
        step();
        wb_wr_en = 1; wb_wr_addr = 5'd9; wb_wr_data = 64'h55;
        step();
        wb_wr_en = 0; wb_wr_data = 64'h66;
        step();
`ifdef FWD_EN
        exp = 64'h55;
`else
        exp = 64'h11;
`endif
        out_ready = 1;
        #1;
        vectors++; if (out_valid !== 1'b1 || rA_64bit_val !== exp) begin miscompares++; $display("FAIL sr_refresh got v=%0b a=%h want v=1 a=%h", out_valid, rA_64bit_val, exp); end
        vectors++; if (rB_64bit_val !== 64'h22) begin miscompares++; $display("FAIL sr_other got=%h want=22", rB_64bit_val); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sr_issue got=%0b want=0", out_valid); end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1; in_instr = mk(OP_VADD, 5'd3, 5'd1, 5'd2, 2'b10, 6'd1); out_ready = 0;
        step();
        in_instr = mk(OP_VAND, 5'd4, 5'd1, 5'd2, 2'b01, 6'd2); flush = 1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fl_ready got=%0b want=0", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_valid got=%0b want=0", out_valid); end
        flush = 0; in_valid = 0; out_ready = 1;
        step();
        vectors++; if (out_valid !== 1'b0 || Op_code !== OP_VADD || rD_addr !== 5'd3) begin miscompares++; $display("FAIL fl_dropped got v=%0b op=%b rd=%0d want v=0 op=101010 rd=3", out_valid, Op_code, rD_addr); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        #12 rst_n = 1;
        #1;
        test_reset();
        test_back_to_back();
        test_ex_forward();
        test_load_use();
        test_stall_refresh();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
